obuf16_tx: RTL
==============

// Module: obuf16_tx
// PURPOSE
//  Transmit-side counterpart of the 16-bit input buffer path: accepts 16-bit words from core
//  logic over a valid/ready handshake, queues them, and drives them onto a registered 16-bit
//  top-level output bus with a one-cycle strobe and an active-low output enable for the pads.
//  Sits between stand control logic and the board connector; all outputs are registered.
// PARAMETERS
//  DEPTH     4        FIFO depth in words, power of 2, >=2
//  GAP       2        idle cycles inserted after each strobed word (0..15)
//  IDLE_VAL  16'h0000 value driven on O while no word is being presented
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  rst_n     in   1   asynchronous active-low reset
//  s_data    in   16  word to transmit
//  s_valid   in   1   s_data valid
//  s_ready   out  1   FIFO can accept; transfer when s_valid & s_ready
//  O         out  16  registered output bus to pad buffers
//  OE_N      out  1   pad output enable, active low
//  STB       out  1   one-cycle strobe, high in the cycle a new word is first on O
//  busy      out  1   FSM not in IDLE or FIFO not empty
//  ovf_cnt   out  8   count of cycles with s_valid high and s_ready low, saturates at 255
// BEHAVIOUR
//  Reset (async, rst_n=0): O=IDLE_VAL, OE_N=1, STB=0, busy=0, ovf_cnt=0, FIFO empty,
//   s_ready=0 while rst_n=0, FSM=IDLE. Any in-flight word and queued data are discarded.
//  FIFO: DEPTH entries, wr/rd pointers one bit wider than log2(DEPTH), wrap naturally.
//   s_ready = !full (registered-free, from pointers). Write on s_valid&s_ready.
//   Simultaneous write and read when full is not allowed (s_ready=0); when empty, a word
//   written in cycle N is readable in cycle N+1 (no fall-through).
//  FSM states: IDLE, SETUP, DRIVE, HOLD.
//   IDLE : OE_N=1, O=IDLE_VAL. If FIFO non-empty -> SETUP.
//   SETUP: OE_N=0, O=IDLE_VAL (one bus turnaround cycle). -> DRIVE.
//   DRIVE: pop FIFO head; O<=head, STB<=1 (registered, so visible the following cycle).
//          -> HOLD with gap counter loaded with GAP.
//   HOLD : STB=0, O holds last word, OE_N=0. Decrement counter each cycle; at 0:
//          FIFO non-empty -> DRIVE; else -> IDLE (O<=IDLE_VAL, OE_N<=1 next cycle).
//          GAP=0: HOLD lasts exactly one cycle, giving one word per 2 cycles maximum.
//  Latency: word accepted into empty FIFO with FSM in IDLE at edge N -> STB=1 and O=word
//   after edge N+3 (IDLE->SETUP->DRIVE->registered output).
//  Back-to-back: while FIFO stays non-empty OE_N stays low, no SETUP between words;
//   strobe period = GAP+2 cycles.
//  STB is never high for two consecutive cycles; O changes only in the cycle STB rises or
//   when returning to IDLE_VAL.
//  ovf_cnt increments on every cycle s_valid=1 & s_ready=0 (rst_n high), holds at 255.
//  busy = (state!=IDLE) | !empty.
// TESTING
//  T1 reset: assert rst_n=0 mid-HOLD with 3 words queued -> O=IDLE_VAL, OE_N=1, STB=0,
//     s_ready=0 immediately; after release FIFO empty, no STB ever produced for old words.
//  T2 single word: push 16'hA5C3 into idle block at edge N -> OE_N=0 after N+2,
//     O=16'hA5C3 & STB=1 after N+3, OE_N=1 & O=IDLE_VAL after N+3+GAP+2.
//  T3 burst GAP=2: push 16'h0001..16'h0004 back-to-back -> 4 STB pulses 4 cycles apart,
//     OE_N low continuously from first SETUP to end, data in order.
//  T4 full: DEPTH=4, hold FSM busy, push 6 words continuously -> s_ready drops after
//     4th accepted; ovf_cnt counts stall cycles; all accepted words emitted in order.
//  T5 pointer wrap: stream 40 random words with random s_valid gaps -> output sequence
//     equals input sequence exactly; compare against scoreboard.
//  T6 GAP=0: burst of 3 words -> STB period 2 cycles, O stable between strobes.

Source files
------------

// File: rtl/obuf16_tx.sv
// obuf16_tx: queues 16-bit words from core logic and presents them on a
// registered pad bus with a one-cycle strobe and an active-low output enable.
// The registered pad outputs lag the FSM state by one cycle: whatever the
// current state decides is what appears on O/OE_N/STB after the next edge.
module obuf16_tx #(
    parameter int          DEPTH    = 4,
    parameter int          GAP      = 2,
    parameter logic [15:0] IDLE_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] O,
    output logic        OE_N,
    output logic        STB,
    output logic        busy,
    output logic [7:0]  ovf_cnt
);

    localparam int         AW    = $clog2(DEPTH);
    localparam logic [3:0] GAP_L = 4'(GAP);

    typedef enum logic [1:0] {IDLE, SETUP, DRIVE, HOLD} state_t;

    state_t         state_q, state_d;
    logic [3:0]     gap_q, gap_d;
    logic [15:0]    o_q, o_d;
    logic           oe_n_q, oe_n_d;
    logic           stb_q, stb_d;
    logic [7:0]     ovf_q;
    logic           rdy_en_q;
    logic [AW:0]    wr_ptr_q, rd_ptr_q;
    logic [15:0]    mem_q [DEPTH];
    logic [15:0]    head;
    logic           empty, full, push, pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // rdy_en_q keeps s_ready low throughout reset without routing rst_n into logic.
    assign s_ready = rdy_en_q & ~full;
    assign push    = s_valid & s_ready;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    assign O       = o_q;
    assign OE_N    = oe_n_q;
    assign STB     = stb_q;
    assign busy    = (state_q != IDLE) | ~empty;
    assign ovf_cnt = ovf_q;

    // FIFO storage: written on accepted handshake, contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_data;
        end
    end

    // FIFO pointers and input-side ready gate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Saturating count of cycles where the source was stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 8'd0;
        end else if (s_valid && !s_ready && (ovf_q != 8'hFF)) begin
            ovf_q <= ovf_q + 8'd1;
        end
    end

    // FSM state, gap counter and registered pad outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gap_q   <= 4'd0;
            o_q     <= IDLE_VAL;
            oe_n_q  <= 1'b1;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            o_q     <= o_d;
            oe_n_q  <= oe_n_d;
            stb_q   <= stb_d;
        end
    end

    // Next-state and next-output decode; HOLD lasts GAP+1 cycles so the
    // strobe period in a burst is GAP+2.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        o_d     = o_q;
        oe_n_d  = oe_n_q;
        stb_d   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                o_d    = IDLE_VAL;
                oe_n_d = 1'b1;
                if (!empty) state_d = SETUP;
            end
            SETUP: begin
                o_d     = IDLE_VAL;
                oe_n_d  = 1'b0;
                state_d = DRIVE;
            end
            DRIVE: begin
                pop     = 1'b1;
                o_d     = head;
                oe_n_d  = 1'b0;
                stb_d   = 1'b1;
                gap_d   = GAP_L;
                state_d = HOLD;
            end
            HOLD: begin
                oe_n_d = 1'b0;
                if (gap_q == 4'd0) begin
                    state_d = empty ? IDLE : DRIVE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
